// File: rtl/block_field_pkg.sv
// Shared definitions for the brick field: level-load pattern encodings and row popcount.
package block_field_pkg;

  typedef enum logic [1:0] {
    LOAD_FULL      = 2'd0,
    LOAD_CHECKER   = 2'd1,
    LOAD_EVEN_ROWS = 2'd2,
    LOAD_EMPTY     = 2'd3
  } load_mode_e;

  // Widest row the popcount helper accepts; callers zero-extend narrower rows.
  localparam int unsigned POP_MAX_W = 64;

  function automatic int unsigned row_popcount(input logic [POP_MAX_W-1:0] bits);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(POP_MAX_W); i++) n += 32'(bits[i]);
    return n;
  endfunction

endpackage

// File: rtl/block_row_gen.sv
// Combinational pattern generator: one brick row for a given row index and load mode.
module block_row_gen
  import block_field_pkg::*;
#(
  parameter int unsigned NUM_COLS = 13,
  parameter int unsigned ROW_W    = 4,
  parameter int unsigned POP_W    = $clog2(NUM_COLS + 1)
) (
  input  logic [ROW_W-1:0]    row,
  input  load_mode_e          mode,
  output logic [NUM_COLS-1:0] bits,
  output logic [POP_W-1:0]    count
);

  logic row_odd;
  assign row_odd = (row & ROW_W'(1)) != '0;

  always_comb begin
    bits = '0;
    case (mode)
      LOAD_FULL:      bits = '1;
      LOAD_CHECKER:   for (int c = 0; c < int'(NUM_COLS); c++) bits[c] = ~(row_odd ^ 1'(c));
      LOAD_EVEN_ROWS: bits = row_odd ? '0 : '1;
      default:        bits = '0;
    endcase
  end

  assign count = POP_W'(row_popcount(POP_MAX_W'(bits)));

endmodule

// File: rtl/block_field.sv
// Brick bitmap with level loader, row scan port for video and test-and-clear hit port.
module block_field
  import block_field_pkg::*;
#(
  parameter int unsigned NUM_ROWS = 16,
  parameter int unsigned NUM_COLS = 13,
  parameter int unsigned ROW_W    = $clog2(NUM_ROWS),
  parameter int unsigned COL_W    = $clog2(NUM_COLS),
  parameter int unsigned CNT_W    = $clog2(NUM_ROWS * NUM_COLS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  input  logic [1:0]          load_mode,
  output logic                busy,
  input  logic                scan_restart,
  input  logic                scan_next,
  output logic [ROW_W-1:0]    scan_row,
  output logic [NUM_COLS-1:0] scan_line,
  input  logic                hit_req,
  input  logic [ROW_W-1:0]    hit_row,
  input  logic [COL_W-1:0]    hit_col,
  output logic                hit_ack,
  output logic                hit_found,
  output logic [CNT_W-1:0]    remaining,
  output logic                all_clear
);

  localparam int unsigned POP_W = $clog2(NUM_COLS + 1);

  typedef enum logic {ST_IDLE, ST_LOAD} state_e;

  state_e              state;
  logic [NUM_COLS-1:0] field [NUM_ROWS];
  logic [ROW_W-1:0]    load_row;
  load_mode_e          load_mode_q;
  logic [NUM_COLS-1:0] gen_bits;
  logic [POP_W-1:0]    gen_count;
  logic                in_range_c;
  logic                hit_hit_c;

  block_row_gen #(
    .NUM_COLS(NUM_COLS),
    .ROW_W   (ROW_W),
    .POP_W   (POP_W)
  ) u_row_gen (
    .row  (load_row),
    .mode (load_mode_q),
    .bits (gen_bits),
    .count(gen_count)
  );

  assign busy      = (state == ST_LOAD);
  assign scan_line = busy ? '0 : field[scan_row];

  // A hit only lands on an in-range, present brick while the loader is idle.
  assign in_range_c = (32'(hit_row) < NUM_ROWS) && (32'(hit_col) < NUM_COLS);
  assign hit_hit_c  = hit_req && (state == ST_IDLE) && in_range_c && field[hit_row][hit_col];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(NUM_ROWS); r++) field[r] <= '0;
      state       <= ST_IDLE;
      load_row    <= '0;
      load_mode_q <= LOAD_EMPTY;
      scan_row    <= '0;
      remaining   <= '0;
      hit_ack     <= 1'b0;
      hit_found   <= 1'b0;
      all_clear   <= 1'b0;
    end else begin
      hit_ack   <= hit_req;
      hit_found <= hit_hit_c;
      all_clear <= 1'b0;

      if (hit_hit_c) begin
        field[hit_row][hit_col] <= 1'b0;
        remaining               <= remaining - CNT_W'(1);
        all_clear               <= (remaining == CNT_W'(1));
      end

      if (scan_restart) begin
        scan_row <= '0;
      end else if (scan_next) begin
        scan_row <= (scan_row == ROW_W'(NUM_ROWS - 1)) ? '0 : scan_row + ROW_W'(1);
      end

      // Load start overrides the hit's remaining update; the hit still sees the old field.
      case (state)
        ST_IDLE: begin
          if (load_start) begin
            state       <= ST_LOAD;
            load_row    <= '0;
            load_mode_q <= load_mode_e'(load_mode);
            remaining   <= '0;
          end
        end
        ST_LOAD: begin
          field[load_row] <= gen_bits;
          remaining       <= remaining + CNT_W'(gen_count);
          load_row        <= load_row + ROW_W'(1);
          if (load_row == ROW_W'(NUM_ROWS - 1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_field.sv
// Directed bench for block_field: a 16x13 field plus a 2x2 field for the all-clear path.
module tb_block_field;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ac_seen = 0;
  int n;

  // 16x13 instance
  logic        load_start, busy, scan_restart, scan_next, hit_req, hit_ack, hit_found, all_clear;
  logic [1:0]  load_mode;
  logic [3:0]  scan_row, hit_row, hit_col;
  logic [12:0] scan_line;
  logic [7:0]  remaining;

  // 2x2 instance
  logic       load_start2, busy2, scan_restart2, scan_next2, hit_req2, hit_ack2, hit_found2, all_clear2;
  logic [1:0] load_mode2;
  logic [0:0] scan_row2, hit_row2, hit_col2;
  logic [1:0] scan_line2;
  logic [2:0] remaining2;

  block_field #(.NUM_ROWS(16), .NUM_COLS(13)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_mode(load_mode), .busy(busy),
    .scan_restart(scan_restart), .scan_next(scan_next), .scan_row(scan_row), .scan_line(scan_line),
    .hit_req(hit_req), .hit_row(hit_row), .hit_col(hit_col), .hit_ack(hit_ack),
    .hit_found(hit_found), .remaining(remaining), .all_clear(all_clear)
  );

  block_field #(.NUM_ROWS(2), .NUM_COLS(2)) dut2 (
    .clk(clk), .rst(rst), .load_start(load_start2), .load_mode(load_mode2), .busy(busy2),
    .scan_restart(scan_restart2), .scan_next(scan_next2), .scan_row(scan_row2), .scan_line(scan_line2),
    .hit_req(hit_req2), .hit_row(hit_row2), .hit_col(hit_col2), .hit_ack(hit_ack2),
    .hit_found(hit_found2), .remaining(remaining2), .all_clear(all_clear2)
  );

  always @(posedge clk) if (!rst && all_clear === 1'b1) ac_seen++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [1:0] mode);
    load_mode = mode; load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Returns the number of edges until busy falls, bounded.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin tick(); cnt++; end
  endtask

  task automatic hit(input int r, input int c);
    hit_row = 4'(r); hit_col = 4'(c); hit_req = 1'b1;
    tick();
    hit_req = 1'b0;
  endtask

  task automatic scan_to(input int r);
    scan_restart = 1'b1; tick(); scan_restart = 1'b0;
    for (int i = 0; i < r; i++) begin scan_next = 1'b1; tick(); scan_next = 1'b0; end
  endtask

  initial begin
    rst = 1'b1;
    {load_start, scan_restart, scan_next, hit_req} = '0;
    load_mode = 2'd0; hit_row = '0; hit_col = '0;
    {load_start2, scan_restart2, scan_next2, hit_req2} = '0;
    load_mode2 = 2'd0; hit_row2 = '0; hit_col2 = '0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_busy", 32'(busy), 0);
    chk("rst_remaining", 32'(remaining), 0);
    chk("rst_scan_row", 32'(scan_row), 0);
    chk("rst_scan_line", 32'(scan_line), 0);
    chk("rst_hit_ack", 32'(hit_ack), 0);

    // Checkerboard load
    load(2'd1);
    chk("ld1_busy_start", 32'(busy), 1);
    chk("ld1_rem_start", 32'(remaining), 0);
    wait_idle(n);
    chk("ld1_busy_cycles", 32'(n), 16);
    chk("ld1_remaining", 32'(remaining), 104);
    chk("ld1_row0", 32'(scan_line), 32'h1555);
    scan_to(1);
    chk("ld1_row1", 32'(scan_line), 32'h0AAA);

    // Full load, double hit on (3,5)
    load(2'd0);
    wait_idle(n);
    chk("ld0_remaining", 32'(remaining), 208);
    hit(3, 5);
    chk("h35_ack", 32'(hit_ack), 1);
    chk("h35_found", 32'(hit_found), 1);
    chk("h35_rem", 32'(remaining), 207);
    tick();
    chk("h35_ack_drop", 32'(hit_ack), 0);
    hit(3, 5);
    chk("h35b_ack", 32'(hit_ack), 1);
    chk("h35b_found", 32'(hit_found), 0);
    chk("h35b_rem", 32'(remaining), 207);
    scan_to(3);
    chk("row3_line", 32'(scan_line), 32'h1FDF);
    hit(0, 13);
    chk("col_oor_found", 32'(hit_found), 0);
    chk("col_oor_rem", 32'(remaining), 207);

    // Hit and scan together: old value this cycle, cleared value afterwards
    hit_row = 4'd3; hit_col = 4'd6; hit_req = 1'b1;
    #1;
    chk("scan_pre_clear", 32'(scan_line), 32'h1FDF);
    tick();
    hit_req = 1'b0;
    chk("scan_post_clear", 32'(scan_line), 32'h1F9F);
    chk("h36_found", 32'(hit_found), 1);

    // Even-rows load
    load(2'd2);
    wait_idle(n);
    chk("ld2_remaining", 32'(remaining), 104);
    hit(1, 4);
    chk("h14_found", 32'(hit_found), 0);
    hit(15, 0);
    chk("h150_found", 32'(hit_found), 0);
    hit(14, 0);
    chk("h140_found", 32'(hit_found), 1);
    chk("h140_rem", 32'(remaining), 103);

    // Scan wrap and restart priority
    scan_to(0);
    for (int i = 0; i < 17; i++) begin scan_next = 1'b1; tick(); end
    scan_next = 1'b0;
    chk("scan_wrap", 32'(scan_row), 1);
    scan_restart = 1'b1; scan_next = 1'b1;
    tick();
    scan_restart = 1'b0; scan_next = 1'b0;
    chk("scan_restart_prio", 32'(scan_row), 0);

    // Activity during a load, then reset at load cycle 5
    load(2'd0);
    chk("busy_line_zero", 32'(scan_line), 0);
    hit(2, 2);
    chk("busy_hit_ack", 32'(hit_ack), 1);
    chk("busy_hit_found", 32'(hit_found), 0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_remaining", 32'(remaining), 0);
    for (int r = 0; r < 16; r++) begin
      chk($sformatf("abort_row%0d", r), 32'(scan_line), 0);
      scan_next = 1'b1; tick(); scan_next = 1'b0;
    end
    load(2'd3);
    chk("relaunch_busy", 32'(busy), 1);
    wait_idle(n);
    chk("ld3_remaining", 32'(remaining), 0);

    // Load and hit at the same edge: hit sees the old field
    load(2'd0);
    wait_idle(n);
    hit_row = 4'd0; hit_col = 4'd0; hit_req = 1'b1;
    load_mode = 2'd2; load_start = 1'b1;
    tick();
    hit_req = 1'b0; load_start = 1'b0;
    chk("lh_ack", 32'(hit_ack), 1);
    chk("lh_found", 32'(hit_found), 1);
    chk("lh_rem", 32'(remaining), 0);
    chk("lh_busy", 32'(busy), 1);
    wait_idle(n);
    chk("lh_final_rem", 32'(remaining), 104);
    scan_to(0);
    chk("lh_row0", 32'(scan_line), 32'h1FFF);
    chk("no_all_clear_main", 32'(ac_seen), 0);

    // 2x2 field: clear all bricks
    load_mode2 = 2'd0; load_start2 = 1'b1;
    tick();
    load_start2 = 1'b0;
    n = 0;
    while (busy2 && n < 100) begin tick(); n++; end
    chk("small_busy_cycles", 32'(n), 2);
    chk("small_remaining", 32'(remaining2), 4);
    for (int k = 0; k < 4; k++) begin
      hit_row2 = 1'(k / 2); hit_col2 = 1'(k % 2); hit_req2 = 1'b1;
      tick();
      hit_req2 = 1'b0;
      chk($sformatf("small_found%0d", k), 32'(hit_found2), 1);
      chk($sformatf("small_rem%0d", k), 32'(remaining2), 32'(3 - k));
      chk($sformatf("small_ac%0d", k), 32'(all_clear2), (k == 3) ? 1 : 0);
    end
    tick();
    chk("small_ac_drop", 32'(all_clear2), 0);
    chk("small_rem_final", 32'(remaining2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_field.md
Name: block_field

Overview:
- Parametrised successor to the breakout block store: holds a NUM_ROWS x NUM_COLS bitmap of live bricks.
- The video path uses a sequential scan port that walks rows one at a time and outputs a row bitmap.
- The ball/collision logic uses a random-access hit port that tests and clears a single brick and reports whether it existed.
- Adds level loading from selectable patterns, a live remaining-brick counter, and a field-cleared pulse for the game FSM.

Parameters:
NUM_ROWS, 16, number of brick rows (>=2)
NUM_COLS, 13, bricks per row (>=2)
ROW_W, $clog2(NUM_ROWS), row index width (derived)
COL_W, $clog2(NUM_COLS), column index width (derived)
CNT_W, $clog2(NUM_ROWS*NUM_COLS+1), remaining-count width (derived)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
load_start  in  1  begin level load (ignored while busy)
load_mode  in  2  pattern: 0 full, 1 checkerboard, 2 even rows full, 3 empty
busy  out  1  load in progress
scan_restart  in  1  scan pointer to row 0
scan_next  in  1  advance scan pointer
scan_row  out  ROW_W  current scan row index
scan_line  out  NUM_COLS  bitmap of current scan row, bit c = column c
hit_req  in  1  test-and-clear request
hit_row  in  ROW_W  target row
hit_col  in  COL_W  target column
hit_ack  out  1  one-cycle response strobe
hit_found  out  1  target brick was present (valid with hit_ack)
remaining  out  CNT_W  live brick count
all_clear  out  1  one-cycle pulse when last brick removed by a hit

Behaviour:
- Reset (sync, rst=1 at edge): all bricks 0, remaining=0, busy=0, scan_row=0, hit_ack=0, hit_found=0, all_clear=0. Reset mid-load aborts the load and leaves the field empty.
- Load: load_start=1 at edge N with busy=0 -> busy=1 from N+1, remaining=0 at N+1. Row k is written at edge N+1+k and remaining += popcount(row k). busy falls at edge N+NUM_ROWS (after row NUM_ROWS-1 is written). Total busy = NUM_ROWS cycles. load_start while busy is ignored; load_mode is sampled only at N.
- Patterns: mode0 all 1s; mode1 bit(r,c)=1 iff (r+c) even; mode2 row all 1s iff r even, else 0; mode3 all 0s.
- Scan: scan_restart has priority over scan_next. scan_next increments scan_row, wrapping NUM_ROWS-1 -> 0. scan_line is combinational from storage at scan_row and is forced to 0 while busy.
- Hit: hit_req sampled at edge N -> hit_ack=1 for exactly the cycle after N.
  - hit_found = brick value before the edge.
  - The brick is cleared at the same edge, and remaining decrements iff hit_found.
  - Out-of-range row/col, or hit_req while busy: ack with hit_found=0 and no state change.
  - Back-to-back hit_req each cycle is supported. Hitting the same brick twice gives found=1 then found=0.
- all_clear: asserted for one cycle when a hit drives remaining 1 -> 0. A load never asserts it, even for mode3.
- Simultaneous events:
  - Hit and scan in the same cycle: scan_line shows the pre-clear value that cycle and the cleared value from the next.
  - load_start and hit_req at the same edge while idle: the hit is processed on the pre-load field (ack/found valid), then the load overwrites the field. remaining follows load semantics (0 at N+1).
- remaining never underflows. Width is as specified, so no wrap occurs.

Decomposition:
- Package block_field_pkg: load_mode encodings (LOAD_FULL, LOAD_CHECKER, LOAD_EVEN_ROWS, LOAD_EMPTY) and the row popcount function.
- Sub-module block_row_gen (combinational): given row index and mode, produces the NUM_COLS pattern row and its popcount. It is instantiated once and driven by the load row counter.
- Storage is a register array NUM_ROWS x NUM_COLS in block_field.

Test Plan:
- Reset then load mode1 (16x13) -> busy high 16 cycles; remaining=104; scan_line row0=13'b1010101010101 (bit0=1), row1=13'b0101010101010.
- Load mode0, hit (3,5) -> ack next cycle, found=1, remaining 208->207; repeat hit (3,5) -> found=0, remaining 207; scan row3 shows bit5=0.
- Load mode2, hit (1,4) -> found=0; hit (15,0) with NUM_ROWS=16 -> found=0 (odd row); hit row=16 (ROW_W=4 prevents this, so use NUM_ROWS=12, row 13) -> found=0, no change.
- Load mode0 with NUM_ROWS=2, NUM_COLS=2 -> remaining=4; clear all four -> all_clear pulses once with the fourth ack; remaining=0.
- scan_next 17 times from 0 (NUM_ROWS=16) -> scan_row=1; scan_restart and scan_next together -> scan_row=0; during load, scan_line=0 and hit_req -> ack with found=0.
- Assert rst at load cycle 5 -> next cycle busy=0, remaining=0, all scan rows 0; a new load_start is accepted immediately.
